// File: rtl/ascon_ctrl_pkg.sv
// Shared constants for the ASCON-128 encryption sequencer: state codes,
// default round counts and key-injection positions.
package ascon_ctrl_pkg;

    localparam int PA_ROUNDS_DEF = 12;
    localparam int PB_ROUNDS_DEF = 6;
    localparam int CNT_W_DEF     = 4;

    localparam logic KEY_POS_INIT = 1'b0;
    localparam logic KEY_POS_FIN  = 1'b1;

    localparam int ST_W = 4;
    localparam logic [ST_W-1:0] S_IDLE       = 4'd0;
    localparam logic [ST_W-1:0] S_INIT_LOAD  = 4'd1;
    localparam logic [ST_W-1:0] S_INIT_PERM  = 4'd2;
    localparam logic [ST_W-1:0] S_INIT_KEY   = 4'd3;
    localparam logic [ST_W-1:0] S_AD_WAIT    = 4'd4;
    localparam logic [ST_W-1:0] S_AD_PERM    = 4'd5;
    localparam logic [ST_W-1:0] S_DOM_SEP    = 4'd6;
    localparam logic [ST_W-1:0] S_DATA_WAIT  = 4'd7;
    localparam logic [ST_W-1:0] S_DATA_PERM  = 4'd8;
    localparam logic [ST_W-1:0] S_FINAL_KEY  = 4'd9;
    localparam logic [ST_W-1:0] S_FINAL_PERM = 4'd10;
    localparam logic [ST_W-1:0] S_TAG        = 4'd11;

endpackage

// File: rtl/ascon_ctrl_fsm_if.sv
// Block-input handshake between the AD/plaintext source (master) and the
// encryption sequencer (slave).
interface ascon_ctrl_fsm_if;
    logic ad_valid_i;
    logic ad_last_i;
    logic ad_ready_o;
    logic data_valid_i;
    logic data_last_i;
    logic data_ready_o;

    modport master (
        output ad_valid_i, ad_last_i, data_valid_i, data_last_i,
        input  ad_ready_o, data_ready_o
    );

    modport slave (
        input  ad_valid_i, ad_last_i, data_valid_i, data_last_i,
        output ad_ready_o, data_ready_o
    );
endinterface

// File: rtl/ascon_round_cnt.sv
// Round-constant index: loadable, increments while enabled, holds at LAST.
// Latency: one cycle from load/inc to new value.
// Backpressure: none; the owning FSM decides when to load or advance.
module ascon_round_cnt #(
    parameter int CNT_W = 4,
    parameter int LAST  = 11
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = (cnt == CNT_W'(LAST));

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && !last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: one permutation round per cycle, init to tag.
// Latency: 38 cycles start-to-done for one AD and one data block with no stalls.
// Backpressure: ready is Moore in the WAIT states; a low valid holds the state.
module ascon_ctrl_fsm
    import ascon_ctrl_pkg::*;
#(
    parameter int PA_ROUNDS = PA_ROUNDS_DEF,
    parameter int PB_ROUNDS = PB_ROUNDS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                     clock_i,
    input  logic                     resetb_i,
    input  logic                     start_i,
    input  logic                     ad_empty_i,
    ascon_ctrl_fsm_if.slave          blk,
    output logic                     perm_en_o,
    output logic                     bypass_o,
    output logic [CNT_W-1:0]         round_o,
    output logic                     init_sel_o,
    output logic                     xor_ext_o,
    output logic                     xor_key_o,
    output logic                     key_pos_o,
    output logic                     xor_dom_o,
    output logic                     key_en_o,
    output logic                     cipher_en_o,
    output logic                     tag_en_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam logic [CNT_W-1:0] ROUND_A0 = '0;
    localparam logic [CNT_W-1:0] ROUND_B0 = CNT_W'(PA_ROUNDS - PB_ROUNDS);

    logic [ST_W-1:0]  state, state_nxt;
    logic             ad_empty_q, ad_last_q;
    logic             cnt_load, cnt_inc, cnt_last, rnd_act;
    logic [CNT_W-1:0] cnt_val, cnt_load_val;
    logic             ad_rdy, data_rdy;

    ascon_round_cnt #(.CNT_W(CNT_W), .LAST(PA_ROUNDS - 1)) u_cnt (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .cnt      (cnt_val),
        .last     (cnt_last)
    );

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = ROUND_A0;
        cnt_inc      = 1'b0;
        rnd_act      = 1'b0;
        ad_rdy       = 1'b0;
        data_rdy     = 1'b0;
        perm_en_o    = 1'b0;
        bypass_o     = 1'b0;
        init_sel_o   = 1'b0;
        xor_ext_o    = 1'b0;
        xor_key_o    = 1'b0;
        key_pos_o    = KEY_POS_INIT;
        xor_dom_o    = 1'b0;
        key_en_o     = 1'b0;
        cipher_en_o  = 1'b0;
        tag_en_o     = 1'b0;
        done_o       = 1'b0;
        case (state)
            S_IDLE: if (start_i) state_nxt = S_INIT_LOAD;
            S_INIT_LOAD: begin
                init_sel_o = 1'b1;
                perm_en_o  = 1'b1;
                key_en_o   = 1'b1;
                bypass_o   = 1'b1;
                cnt_load   = 1'b1;
                state_nxt  = S_INIT_PERM;
            end
            S_INIT_PERM: begin
                perm_en_o = 1'b1;
                rnd_act   = 1'b1;
                cnt_inc   = 1'b1;
                if (cnt_last) state_nxt = S_INIT_KEY;
            end
            // Key XOR is a bypass pass of the state, so it needs the register enable to land.
            S_INIT_KEY: begin
                bypass_o  = 1'b1;
                xor_key_o = 1'b1;
                perm_en_o = 1'b1;
                key_pos_o = KEY_POS_INIT;
                state_nxt = ad_empty_q ? S_DOM_SEP : S_AD_WAIT;
            end
            S_AD_WAIT: begin
                ad_rdy = 1'b1;
                if (blk.ad_valid_i) begin
                    xor_ext_o    = 1'b1;
                    bypass_o     = 1'b1;
                    perm_en_o    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = ROUND_B0;
                    state_nxt    = S_AD_PERM;
                end
            end
            S_AD_PERM: begin
                perm_en_o = 1'b1;
                rnd_act   = 1'b1;
                cnt_inc   = 1'b1;
                if (cnt_last) state_nxt = ad_last_q ? S_DOM_SEP : S_AD_WAIT;
            end
            S_DOM_SEP: begin
                bypass_o  = 1'b1;
                xor_dom_o = 1'b1;
                perm_en_o = 1'b1;
                state_nxt = S_DATA_WAIT;
            end
            S_DATA_WAIT: begin
                data_rdy = 1'b1;
                if (blk.data_valid_i) begin
                    xor_ext_o   = 1'b1;
                    bypass_o    = 1'b1;
                    perm_en_o   = 1'b1;
                    cipher_en_o = 1'b1;
                    if (blk.data_last_i) begin
                        state_nxt = S_FINAL_KEY;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = ROUND_B0;
                        state_nxt    = S_DATA_PERM;
                    end
                end
            end
            S_DATA_PERM: begin
                perm_en_o = 1'b1;
                rnd_act   = 1'b1;
                cnt_inc   = 1'b1;
                if (cnt_last) state_nxt = S_DATA_WAIT;
            end
            S_FINAL_KEY: begin
                bypass_o  = 1'b1;
                xor_key_o = 1'b1;
                perm_en_o = 1'b1;
                key_pos_o = KEY_POS_FIN;
                cnt_load  = 1'b1;
                state_nxt = S_FINAL_PERM;
            end
            S_FINAL_PERM: begin
                perm_en_o = 1'b1;
                rnd_act   = 1'b1;
                cnt_inc   = 1'b1;
                if (cnt_last) state_nxt = S_TAG;
            end
            S_TAG: begin
                tag_en_o  = 1'b1;
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round index is only meaningful while a round is applied; keep it quiet otherwise.
    assign round_o          = rnd_act ? cnt_val : '0;
    assign busy_o           = (state != S_IDLE);
    assign blk.ad_ready_o   = ad_rdy;
    assign blk.data_ready_o = data_rdy;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state      <= S_IDLE;
            ad_empty_q <= 1'b0;
            ad_last_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start_i) ad_empty_q <= ad_empty_i;
            if (state == S_AD_WAIT && blk.ad_valid_i) ad_last_q <= blk.ad_last_i;
        end
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: per-cycle expected trace built from the encryption
// phase sequence, replayed as a table of {inputs, expected outputs} records.
module tb_ascon_ctrl_fsm;

    localparam int PA = 12;
    localparam int PB = 6;

    typedef struct packed {
        logic start, ad_empty, ad_valid, ad_last, data_valid, data_last;
    } in_t;

    typedef struct packed {
        logic       ad_rdy, data_rdy, perm_en, bypass;
        logic [3:0] rnd;
        logic       init_sel, xor_ext, xor_key, key_pos, xor_dom;
        logic       key_en, cipher_en, tag_en, busy, done;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clock_i = 1'b0;
    logic resetb_i = 1'b0;
    logic start_i = 1'b0;
    logic ad_empty_i = 1'b0;
    logic perm_en_o, bypass_o, init_sel_o, xor_ext_o, xor_key_o, key_pos_o;
    logic xor_dom_o, key_en_o, cipher_en_o, tag_en_o, busy_o, done_o;
    logic [3:0] round_o;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    ascon_ctrl_fsm_if bif ();

    ascon_ctrl_fsm #(.PA_ROUNDS(PA), .PB_ROUNDS(PB), .CNT_W(4)) dut (
        .clock_i     (clock_i),
        .resetb_i    (resetb_i),
        .start_i     (start_i),
        .ad_empty_i  (ad_empty_i),
        .blk         (bif),
        .perm_en_o   (perm_en_o),
        .bypass_o    (bypass_o),
        .round_o     (round_o),
        .init_sel_o  (init_sel_o),
        .xor_ext_o   (xor_ext_o),
        .xor_key_o   (xor_key_o),
        .key_pos_o   (key_pos_o),
        .xor_dom_o   (xor_dom_o),
        .key_en_o    (key_en_o),
        .cipher_en_o (cipher_en_o),
        .tag_en_o    (tag_en_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clock_i = ~clock_i;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1, "timeout");
    end

    function automatic out_t observe();
        out_t o;
        o = {bif.ad_ready_o, bif.data_ready_o, perm_en_o, bypass_o, round_o,
             init_sel_o, xor_ext_o, xor_key_o, key_pos_o, xor_dom_o,
             key_en_o, cipher_en_o, tag_en_o, busy_o, done_o};
        return o;
    endfunction

    function automatic in_t rnd_in(input bit junk);
        in_t i;
        i.start      = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        i.ad_empty   = 1'($urandom_range(0, 1));
        i.ad_valid   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        i.ad_last    = 1'($urandom_range(0, 1));
        i.data_valid = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        i.data_last  = 1'($urandom_range(0, 1));
        return i;
    endfunction

    function automatic out_t busy_only();
        out_t e;
        e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic push(input in_t i, input out_t e);
        vec_t v;
        v.in  = i;
        v.exp = e;
        tbl.push_back(v);
    endtask

    // A run of permutation rounds first..PA-1, with whatever junk is on the inputs.
    task automatic push_rounds(input int first, input bit junk);
        out_t e;
        for (int r = first; r < PA; r++) begin
            e = busy_only();
            e.perm_en = 1'b1;
            e.rnd = 4'(r);
            push(rnd_in(junk), e);
        end
    endtask

    // Expected trace of one encryption, starting with the start cycle in IDLE.
    task automatic gen(input bit empty, input int n_ad, input int n_data,
                       input int stall_blk, input int stall_n, input bit rstall, input bit junk);
        in_t i;
        out_t e;
        int s;
        i = rnd_in(junk); i.start = 1'b1; i.ad_empty = empty;
        push(i, '0);
        e = busy_only(); e.init_sel = 1; e.perm_en = 1; e.key_en = 1; e.bypass = 1;
        push(rnd_in(junk), e);
        push_rounds(0, junk);
        e = busy_only(); e.bypass = 1; e.xor_key = 1; e.perm_en = 1; e.key_pos = 0;
        push(rnd_in(junk), e);
        for (int b = 0; b < n_ad; b++) begin
            s = rstall ? $urandom_range(0, 2) : 0;
            for (int k = 0; k < s; k++) begin
                i = rnd_in(junk); i.ad_valid = 1'b0;
                e = busy_only(); e.ad_rdy = 1;
                push(i, e);
            end
            i = rnd_in(junk); i.ad_valid = 1'b1; i.ad_last = (b == n_ad - 1);
            e = busy_only(); e.ad_rdy = 1; e.xor_ext = 1; e.bypass = 1; e.perm_en = 1;
            push(i, e);
            push_rounds(PA - PB, junk);
        end
        e = busy_only(); e.bypass = 1; e.xor_dom = 1; e.perm_en = 1;
        push(rnd_in(junk), e);
        for (int b = 0; b < n_data; b++) begin
            s = (b == stall_blk) ? stall_n : (rstall ? $urandom_range(0, 2) : 0);
            for (int k = 0; k < s; k++) begin
                i = rnd_in(junk); i.data_valid = 1'b0;
                e = busy_only(); e.data_rdy = 1;
                push(i, e);
            end
            i = rnd_in(junk); i.data_valid = 1'b1; i.data_last = (b == n_data - 1);
            e = busy_only(); e.data_rdy = 1; e.xor_ext = 1; e.bypass = 1;
            e.perm_en = 1; e.cipher_en = 1;
            push(i, e);
            if (b != n_data - 1) push_rounds(PA - PB, junk);
        end
        e = busy_only(); e.bypass = 1; e.xor_key = 1; e.key_pos = 1; e.perm_en = 1;
        push(rnd_in(junk), e);
        push_rounds(0, junk);
        e = busy_only(); e.tag_en = 1; e.done = 1;
        push(rnd_in(junk), e);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic run_table(input string name, input int n, output int done_at,
                             output int n_ci, output int n_dom, output int n_adhs);
        out_t obs;
        done_at = -1; n_ci = 0; n_dom = 0; n_adhs = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clock_i);
            start_i          = tbl[k].in.start;
            ad_empty_i       = tbl[k].in.ad_empty;
            bif.ad_valid_i   = tbl[k].in.ad_valid;
            bif.ad_last_i    = tbl[k].in.ad_last;
            bif.data_valid_i = tbl[k].in.data_valid;
            bif.data_last_i  = tbl[k].in.data_last;
            #1;
            obs = observe();
            checks++;
            if (obs !== tbl[k].exp) begin
                errors++;
                $display("FAIL %s cycle %0d: outputs got %h expected %h", name, k, obs, tbl[k].exp);
            end
            if (obs.done && done_at < 0) done_at = k;
            if (obs.cipher_en) n_ci++;
            if (obs.xor_dom) n_dom++;
            if (obs.ad_rdy && bif.ad_valid_i) n_adhs++;
        end
    endtask

    task automatic scen(input string name, input bit empty, input int n_ad, input int n_data,
                        input int stall_blk, input int stall_n, input bit rstall,
                        input bit junk, input int exp_done);
        int d, ci, dm, ah;
        tbl.delete();
        gen(empty, n_ad, n_data, stall_blk, stall_n, rstall, junk);
        run_table(name, tbl.size(), d, ci, dm, ah);
        chk({name, " done cycle"}, d, (exp_done < 0) ? tbl.size() - 1 : exp_done);
        chk({name, " cipher_en pulses"}, ci, n_data);
        chk({name, " xor_dom pulses"}, dm, 1);
        chk({name, " AD handshakes"}, ah, n_ad);
    endtask

    initial begin
        int d, ci, dm, ah, na;
        bif.ad_valid_i = 0; bif.ad_last_i = 0;
        bif.data_valid_i = 0; bif.data_last_i = 0;

        // Reset state: everything low, even with requests pending.
        repeat (2) @(negedge clock_i);
        start_i = 1; bif.ad_valid_i = 1; bif.data_valid_i = 1;
        #1;
        chk("reset outputs", int'(observe()), 0);
        start_i = 0; bif.ad_valid_i = 0; bif.data_valid_i = 0;
        @(negedge clock_i);
        resetb_i = 1;

        // Abort in INIT_PERM at round 5 (cycle 7 after start).
        tbl.delete();
        gen(0, 1, 1, -1, 0, 0, 0);
        run_table("abort", 8, d, ci, dm, ah);
        chk("abort round before reset", int'(round_o), 5);
        resetb_i = 0;
        #1;
        chk("abort outputs in reset", int'(observe()), 0);
        @(negedge clock_i);
        chk("abort outputs after edge", int'(observe()), 0);
        chk("abort no done", int'(done_o), 0);
        resetb_i = 1;

        scen("basic", 0, 1, 1, -1, 0, 0, 0, 37);
        scen("ad_empty", 1, 0, 1, -1, 0, 0, 0, 30);
        scen("multi_nostall", 0, 2, 3, -1, 0, 0, 0, 58);
        scen("multi_stall", 0, 2, 3, 1, 3, 0, 0, 61);
        scen("junk_inputs", 0, 1, 1, -1, 0, 0, 1, 37);

        for (int t = 0; t < 8; t++) begin
            na = $urandom_range(0, 3);
            scen($sformatf("rand%0d", t), (na == 0), na, $urandom_range(1, 3),
                 -1, 0, 1, 1, -1);
        end

        // Back in IDLE: no ready without a start, even with valids high.
        @(negedge clock_i);
        start_i = 0; bif.ad_valid_i = 1; bif.data_valid_i = 1;
        #1;
        chk("idle no ready", int'({bif.ad_ready_o, bif.data_ready_o, busy_o}), 0);
        bif.ad_valid_i = 0; bif.data_valid_i = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
